// File: rtl/mdu_issue_ctrl_if.sv
// Handshake bundle between the D/E pipeline, the MDU and the MDU issue controller.
// "master" is the controller's view; "slave" is the pipeline/MDU environment's view.
interface mdu_issue_ctrl_if;
    logic [3:0] md_op_d;
    logic       flush_e;
    logic       mdu_busy;
    logic       start;
    logic [2:0] mdu_op;
    logic       hi_write;
    logic       lo_write;
    logic       stall_d;
    logic       busy_shadow;
    logic       chk_err;

    modport master (
        input  md_op_d, flush_e, mdu_busy,
        output start, mdu_op, hi_write, lo_write, stall_d, busy_shadow, chk_err
    );

    modport slave (
        output md_op_d, flush_e, mdu_busy,
        input  start, mdu_op, hi_write, lo_write, stall_d, busy_shadow, chk_err
    );
endinterface

// File: rtl/mdu_issue_ctrl.sv
// E-stage MDU initiator: holds the E copy of MD-class ops, issues them, shadows MDU busy and stalls D.
// Optional macro MDU_BUSY_CHECK_EN adds a sticky compare of the real MDU busy against the shadow.
module mdu_issue_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 9,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    mdu_issue_ctrl_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [3:0]       op_e_r;
    logic [3:0]       op_d_s;
    logic             busy_shadow_r;
    logic             start_s;
    logic             is_md_d_s;
    logic             stall_d_s;
    logic [2:0]       mdu_op_s;

    // Codes 9..15 carry no MD meaning and collapse to "none".
    function automatic logic [3:0] norm_op(input logic [3:0] op);
        return (op > 4'd8) ? 4'd0 : op;
    endfunction

    // Decode of the D-stage request and the E-stage slot.
    always_comb begin
        op_d_s    = norm_op(bus.md_op_d);
        is_md_d_s = (op_d_s != 4'd0);
        start_s   = (op_e_r >= 4'd1) && (op_e_r <= 4'd4);
        stall_d_s = is_md_d_s && (start_s || busy_shadow_r);
        mdu_op_s  = start_s ? (op_e_r[2:0] - 3'd1) : 3'd0;
    end

    // Next-state logic; a start seen while running is ignored and never reloads the counter.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    if (op_e_r <= 4'd2) begin
                        state_nxt_s = MUL_RUN;
                        cnt_nxt_s   = CNT_W'(MUL_LAT);
                    end else begin
                        state_nxt_s = DIV_RUN;
                        cnt_nxt_s   = CNT_W'(DIV_LAT);
                    end
                end else begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end
            end
            MUL_RUN, DIV_RUN: begin
                if (cnt_r == CNT_W'(1)) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s = state_r;
                    cnt_nxt_s   = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // E slot, FSM state, counter and shadow busy registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_e_r        <= 4'd0;
            state_r       <= IDLE;
            cnt_r         <= {CNT_W{1'b0}};
            busy_shadow_r <= 1'b0;
        end else begin
            op_e_r        <= (stall_d_s || bus.flush_e) ? 4'd0 : op_d_s;
            state_r       <= state_nxt_s;
            cnt_r         <= cnt_nxt_s;
            busy_shadow_r <= (state_nxt_s != IDLE);
        end
    end

    assign bus.start       = start_s;
    assign bus.mdu_op      = mdu_op_s;
    assign bus.hi_write    = (op_e_r == 4'd5);
    assign bus.lo_write    = (op_e_r == 4'd6);
    assign bus.stall_d     = stall_d_s;
    assign bus.busy_shadow = busy_shadow_r;

`ifdef MDU_BUSY_CHECK_EN
    logic chk_err_r;

    // Sticky disagreement flag between the real MDU busy and the shadow.
    always_ff @(posedge clk) begin
        if (!reset) begin
            chk_err_r <= 1'b0;
        end else if (bus.mdu_busy != busy_shadow_r) begin
            chk_err_r <= 1'b1;
        end else begin
            chk_err_r <= chk_err_r;
        end
    end

`ifndef SYNTHESIS
    logic [31:0] cycle_r;

    // Cycle stamp and report for busy disagreements.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_r <= 32'd0;
        end else begin
            cycle_r <= cycle_r + 32'd1;
            if (bus.mdu_busy != busy_shadow_r) begin
                $display("mdu_issue_ctrl: busy disagreement cycle=%0d state=%s cnt=%0d",
                         cycle_r, state_r.name(), cnt_r);
            end
        end
    end
`endif

    assign bus.chk_err = chk_err_r;
`else
    assign bus.chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Scoreboard bench for mdu_issue_ctrl: expected issue events and busy run lengths are queued at stimulus time.
module tb_mdu_issue_ctrl;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 9;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mdu_issue_ctrl_if bus();

    mdu_issue_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [31:0] ev_q[$];
    int          run_q[$];
    int          run_len = 0;

`ifdef MDU_BUSY_CHECK_EN
    localparam logic EXP_CHK = 1'b1;
`else
    localparam logic EXP_CHK = 1'b0;
`endif

    // Behavioural MDU: busy for the op latency after each accepted start.
    int   mdl_cnt = 0;
    logic force_idle = 1'b0;
    always @(posedge clk) begin
        if (!reset) mdl_cnt <= 0;
        else if (mdl_cnt != 0) mdl_cnt <= mdl_cnt - 1;
        else if (bus.start) mdl_cnt <= (bus.mdu_op < 3'd2) ? MUL_LAT : DIV_LAT;
    end
    assign bus.mdu_busy = (mdl_cnt != 0) && !force_idle;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ev_start(input int op);
        return 32'h20 | (op & 32'h7);
    endfunction
    localparam logic [31:0] EV_HI = 32'h10;
    localparam logic [31:0] EV_LO = 32'h08;

    // Output monitor: pops expected issue events and busy run lengths.
    always @(negedge clk) begin
        logic [31:0] ev;
        ev = {26'd0, bus.start, bus.hi_write, bus.lo_write, bus.mdu_op};
        if (ev != 32'd0) begin
            if (ev_q.size() == 0) check_val("unexpected_issue", ev, 32'd0);
            else check_val("issue_event", ev, ev_q.pop_front());
        end
        if (bus.busy_shadow) begin
            run_len++;
        end else if (run_len != 0) begin
            if (run_q.size() == 0) check_val("unexpected_busy", run_len, 0);
            else check_val("busy_run", run_len, run_q.pop_front());
            run_len = 0;
        end
    end

    // Present op in D, count stall cycles until it is accepted, then let the edge take it.
    task automatic send(input logic [3:0] op, input logic flush, input int exp_stalls, input string tag);
        int stalls = 0;
        bit done = 1'b0;
        bus.md_op_d = op;
        bus.flush_e = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            #1;
            if (bus.stall_d) begin
                stalls++;
                @(negedge clk);
            end else begin
                done = 1'b1;
            end
        end
        if (!done) check_val({tag, "_timeout"}, 32'd0, 32'd1);
        bus.flush_e = flush;
        @(negedge clk);
        bus.flush_e = 1'b0;
        bus.md_op_d = 4'd0;
        check_val({tag, "_stalls"}, stalls, exp_stalls);
    endtask

    task automatic idle(input int n);
        bus.md_op_d = 4'd0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.md_op_d = 4'd1;
        bus.flush_e = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_start",    bus.start,       32'd0);
        check_val("rst_mdu_op",   bus.mdu_op,      32'd0);
        check_val("rst_hi",       bus.hi_write,    32'd0);
        check_val("rst_lo",       bus.lo_write,    32'd0);
        check_val("rst_stall",    bus.stall_d,     32'd0);
        check_val("rst_busy",     bus.busy_shadow, 32'd0);
        check_val("rst_chk_err",  bus.chk_err,     32'd0);
        reset = 1'b1;

        // mult straight out of reset
        ev_q.push_back(ev_start(0)); run_q.push_back(MUL_LAT);
        send(4'd1, 1'b0, 0, "mult_first");
        idle(6);

        // divu then mflo waits start + 9 busy cycles
        ev_q.push_back(ev_start(3)); run_q.push_back(DIV_LAT);
        send(4'd4, 1'b0, 0, "divu");
        send(4'd8, 1'b0, DIV_LAT + 1, "mflo_after_divu");
        idle(2);

        // multu, add, mthi
        ev_q.push_back(ev_start(1)); run_q.push_back(MUL_LAT);
        send(4'd2, 1'b0, 0, "multu");
        send(4'd0, 1'b0, 0, "add_in_shadow");
        ev_q.push_back(EV_HI);
        send(4'd5, 1'b0, MUL_LAT, "mthi_after_multu");
        idle(2);

        // mult, reserved code 15, mtlo
        ev_q.push_back(ev_start(0)); run_q.push_back(MUL_LAT);
        send(4'd1, 1'b0, 0, "mult");
        send(4'd15, 1'b0, 0, "op15_none");
        ev_q.push_back(EV_LO);
        send(4'd6, 1'b0, MUL_LAT, "mtlo_after_mult");
        idle(2);

        // back-to-back multiplies
        ev_q.push_back(ev_start(0)); run_q.push_back(MUL_LAT);
        send(4'd1, 1'b0, 0, "mult_a");
        ev_q.push_back(ev_start(1)); run_q.push_back(MUL_LAT);
        send(4'd2, 1'b0, MUL_LAT + 1, "multu_b2b");
        idle(6);

        // flushed div never issues
        send(4'd3, 1'b1, 0, "div_flushed");
        check_val("flush_start", bus.start,       32'd0);
        check_val("flush_busy",  bus.busy_shadow, 32'd0);
        send(4'd7, 1'b0, 0, "mfhi_after_flush");
        check_val("flush_busy2", bus.busy_shadow, 32'd0);
        idle(2);

        // reset in the middle of a divide (cnt==5)
        ev_q.push_back(ev_start(2)); run_q.push_back(5);
        send(4'd3, 1'b0, 0, "div_for_reset");
        repeat (5) @(negedge clk);
        reset = 1'b0;
        bus.md_op_d = 4'd8;
        @(negedge clk);
        check_val("midrst_busy",  bus.busy_shadow, 32'd0);
        check_val("midrst_start", bus.start,       32'd0);
        check_val("midrst_stall", bus.stall_d,     32'd0);
        reset = 1'b1;
        ev_q.push_back(ev_start(0)); run_q.push_back(MUL_LAT);
        send(4'd1, 1'b0, 0, "mult_after_reset");
        idle(6);

        // real MDU busy forced low for one cycle during a mult
        ev_q.push_back(ev_start(0)); run_q.push_back(MUL_LAT);
        send(4'd1, 1'b0, 0, "mult_chk");
        check_val("chk_before", bus.chk_err, 32'd0);
        @(negedge clk);
        force_idle = 1'b1;
        @(negedge clk);
        force_idle = 1'b0;
        check_val("chk_set", bus.chk_err, {31'd0, EXP_CHK});
        repeat (4) @(negedge clk);
        check_val("chk_sticky", bus.chk_err, {31'd0, EXP_CHK});
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_val("chk_cleared", bus.chk_err, 32'd0);
        idle(4);

        check_val("events_drained", ev_q.size(), 32'd0);
        check_val("runs_drained",   run_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
